// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state enum and its encodings.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder cell (module full_adder), the only arithmetic element of serial_adder.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic sum,
  output logic carry
);

  assign sum   = A ^ B ^ Cin;
  assign carry = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: {carry,sum} = A + B + Cin over WIDTH cycles, LSB first.
// Optional two's-complement overflow output when SERIAL_ADDER_OVF_EN is defined.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] opa, opb;
  logic             cff;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_c;
  logic [WIDTH-1:0] res_full;
  logic             last;

  full_adder u_fa (
    .A    (opa[0]),
    .B    (opb[0]),
    .Cin  (cff),
    .sum  (fa_s),
    .carry(fa_c)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  // res_full is the result register as it will read after this shift;
  // only WIDTH-1 bits need storing since the MSB comes straight from the cell.
  if (WIDTH == 1) begin : g_one
    assign res_full = fa_s;
  end else begin : g_multi
    logic [WIDTH-2:0] res;
    always_ff @(posedge clk) begin
      if (rst)                 res <= '0;
      else if (state == SHIFT) res <= res_full[WIDTH-1:1];
    end
    assign res_full = {fa_s, res};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      cff   <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            opa   <= A;
            opb   <= B;
            cff   <= Cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          opa <= opa >> 1;
          opb <= opb >> 1;
          cff <= fa_c;
          cnt <= cnt + CW'(1);
          if (last) begin
            sum   <= res_full;
            carry <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
            // cff holds the carry into the MSB on the final bit
            ovf   <= cff ^ fa_c;
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed cases plus random ops vs an arithmetic model.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, Cin;
  logic [W-1:0] A, B;
  logic         busy, done, carry;
  logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int fails  = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .carry(carry)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one op, scramble the inputs while it runs, report latency and busy cycles.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        output int lat, output int bcnt);
    A = a; B = b; Cin = c; start = 1'b1;
    step();
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
    lat  = 0;
    bcnt = int'(busy);
    for (int i = 0; i < 40; i++) begin
      step();
      lat++;
      if (done) break;
      bcnt += int'(busy);
    end
  endtask

  task automatic op_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c);
    int lat, bcnt;
    logic [W:0] ref_full;
    ref_full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    run_op(a, b, c, lat, bcnt);
    chk({tag, ".lat"},   lat, W);
    chk({tag, ".busy"},  bcnt, W);
    chk({tag, ".sum"},   sum, ref_full[W-1:0]);
    chk({tag, ".carry"}, carry, ref_full[W]);
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, ".ovf"}, ovf, (a[W-1] == b[W-1]) && (ref_full[W-1] != a[W-1]));
`endif
    step();
    chk({tag, ".donefall"}, done, 1'b0);
  endtask

  initial begin
    int seen, t, t1, t2;
    logic [W-1:0] s1, s2;

    rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    step(); step();
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.sum", sum, 0);
    chk("rst.carry", carry, 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst.ovf", ovf, 0);
`endif
    rst = 1'b0;
    step();

    op_check("d35_4a", 8'h35, 8'h4A, 1'b0);
    op_check("dff_01", 8'hFF, 8'h01, 1'b0);
    op_check("dff_00c", 8'hFF, 8'h00, 1'b1);
    op_check("d00_00", 8'h00, 8'h00, 1'b0);
    op_check("dff_ffc", 8'hFF, 8'hFF, 1'b1);
`ifdef SERIAL_ADDER_OVF_EN
    op_check("o7f_01", 8'h7F, 8'h01, 1'b0);
    chk("o7f_01.ovf1", ovf, 1);
    op_check("off_01", 8'hFF, 8'h01, 1'b0);
    chk("off_01.ovf0", ovf, 0);
`endif

    // Start pulse mid-operation is ignored
    A = 8'h35; B = 8'h4A; Cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    A = 8'h11; B = 8'h22; start = 1'b1;
    step();
    start = 1'b0;
    seen = 0; t1 = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) begin
        seen++;
        if (t1 < 0) begin t1 = i; s1 = sum; end
      end
    end
    chk("ign.ndone", seen, 1);
    chk("ign.sum", s1, 8'h7F);
    chk("ign.busy", busy, 0);

    // Reset aborts an operation with no done pulse
    A = 8'hAA; B = 8'h55; Cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort.busy", busy, 0);
    chk("abort.sum", sum, 0);
    chk("abort.carry", carry, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      seen += int'(done);
    end
    chk("abort.ndone", seen, 0);
    op_check("post01", 8'h01, 8'h01, 1'b0);
    chk("post01.sumv", sum, 8'h02);

    // Reset wins over start on the same edge
    rst = 1'b1; start = 1'b1; A = 8'h12; B = 8'h34;
    step();
    rst = 1'b0; start = 1'b0;
    chk("rststart.busy", busy, 0);
    step();
    chk("rststart.idle", busy, 0);

    // Back-to-back with start held high
    A = 8'h10; B = 8'h20; Cin = 1'b0; start = 1'b1;
    step();
    A = 8'h0F; B = 8'h01;
    t = 0; t1 = -1; t2 = -1; s1 = '0; s2 = '0;
    for (int i = 0; i < 30; i++) begin
      step();
      t++;
      if (done) begin
        if (t1 < 0) begin t1 = t; s1 = sum; end
        else if (t2 < 0) begin t2 = t; s2 = sum; start = 1'b0; end
      end
      if (t2 >= 0) break;
    end
    start = 1'b0;
    chk("b2b.t1", t1, W);
    chk("b2b.gap", t2 - t1, W + 1);
    chk("b2b.s1", s1, 8'h30);
    chk("b2b.s2", s2, 8'h10);
    step(); step();

    // Random ops against the arithmetic model
    for (int k = 0; k < 25; k++) begin
      op_check("rnd", W'($urandom), W'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
